// File: rtl/present_decrypt.sv
// PRESENT-80 decryption core: forward key expansion to K32, then 31
// inverse rounds at one round per clock; plaintext returned as two words.
module present_decrypt #(
  parameter int NROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] key,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dout,
  output logic        done1,
  output logic        done2,
  output logic [3:0]  state
);

  localparam logic [4:0] LAST_RC = 5'(NROUNDS);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD_LO = 4'd1,
    KEYEXP  = 4'd2,
    ROUND   = 4'd3,
    FINAL   = 4'd4,
    OUT_HI  = 4'd5,
    OUT_LO  = 4'd6
  } state_t;

  state_t      cur, nxt;
  logic [63:0] ct, st, pt;
  logic [79:0] kreg;
  logic [4:0]  rc;
  logic        accept_hi, accept_lo;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hC56B90AD3EF84712;
    return t[4*(15-int'(x)) +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h5EF8C12DB463079A;
    return t[4*(15-int'(x)) +: 4];
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++)
      y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
    return y;
  endfunction

  // P sends bit i to 16*i mod 63, so output bit i is pulled from there
  function automatic logic [63:0] inv_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 63; i++)
      y[i] = x[(16*i) % 63];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] key_fwd(
    input logic [79:0] k,
    input logic [4:0]  c
  );
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ c;
    return r;
  endfunction

  function automatic logic [79:0] key_inv(
    input logic [79:0] k,
    input logic [4:0]  c
  );
    logic [79:0] r;
    r = k;
    r[19:15] = r[19:15] ^ c;
    r[79:76] = inv_sbox(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  assign state = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt       = cur;
    din_ready = 1'b0;
    accept_hi = 1'b0;
    accept_lo = 1'b0;
    unique case (cur)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          accept_hi = 1'b1;
          nxt       = LOAD_LO;
        end
      end
      LOAD_LO: begin
        din_ready = 1'b1;
        if (din_valid) begin
          accept_lo = 1'b1;
          nxt       = KEYEXP;
        end
      end
      KEYEXP:  if (rc == LAST_RC) nxt = ROUND;
      ROUND:   if (rc == 5'd1) nxt = FINAL;
      FINAL:   nxt = OUT_HI;
      OUT_HI:  nxt = OUT_LO;
      OUT_LO:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct    <= '0;
      st    <= '0;
      pt    <= '0;
      kreg  <= '0;
      rc    <= '0;
      dout  <= '0;
      done1 <= 1'b0;
      done2 <= 1'b0;
    end else begin
      done1 <= 1'b0;
      done2 <= 1'b0;
      unique case (cur)
        IDLE: begin
          if (accept_hi) begin
            ct[63:32] <= din;
            kreg      <= key;
          end
        end
        LOAD_LO: begin
          if (accept_lo) begin
            ct[31:0] <= din;
            rc       <= 5'd1;
          end
        end
        KEYEXP: begin
          kreg <= key_fwd(kreg, rc);
          if (rc == LAST_RC) begin
            rc <= LAST_RC;
            st <= ct;
          end else begin
            rc <= rc + 5'd1;
          end
        end
        ROUND: begin
          st   <= inv_sbox_layer(inv_perm(st ^ kreg[79:16]));
          kreg <= key_inv(kreg, rc);
          rc   <= rc - 5'd1;
        end
        FINAL: pt <= st ^ kreg[79:16];
        OUT_HI: begin
          dout  <= pt[63:32];
          done1 <= 1'b1;
        end
        OUT_LO: begin
          dout  <= pt[31:0];
          done2 <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_decrypt.sv
// Directed bench for present_decrypt using published PRESENT-80 vectors.
// Checks plaintext words, strobe latency, handshake and reset abort.
module tb_present_decrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] key;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        done1;
  logic        done2;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] K1 = {80{1'b1}};
  localparam logic [63:0] P0 = 64'h0;
  localparam logic [63:0] P1 = 64'hFFFFFFFFFFFFFFFF;

  present_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .done1     (done1),
    .done2     (done2),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; caller must be in IDLE.
  task automatic decrypt(
    input string       tag,
    input logic [79:0] k,
    input logic [63:0] c,
    input int          gap,
    input bit          junk,
    input logic [63:0] exp_pt
  );
    int          n;
    int          t1;
    int          t2;
    int          bad_rdy;
    int          bad_wait;
    logic [31:0] hi;
    logic [31:0] lo;
    t1 = -1;
    t2 = -1;
    bad_rdy = 0;
    bad_wait = 0;
    hi = '0;
    lo = '0;
    chk({tag, ".rdy_idle"}, 64'(din_ready), 64'd1);
    key = k;
    din = c[63:32];
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = 32'hDEADBEEF;
    key = ~k;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (din_ready !== 1'b1 || state !== 4'd1) bad_wait++;
    end
    chk({tag, ".load_lo"}, 64'(state), 64'd1);
    din = c[31:0];
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    n = 0;
    while (t2 < 0 && n < 100) begin
      if (din_ready !== 1'b0) bad_rdy++;
      if (junk) begin
        din_valid = 1'($urandom);
        din = $urandom;
        key = {$urandom, $urandom, 16'($urandom)};
      end
      @(negedge clk);
      n++;
      if (done1) begin
        t1 = n;
        hi = dout;
      end
      if (done2) begin
        t2 = n;
        lo = dout;
      end
    end
    din_valid = 1'b0;
    chk({tag, ".gap_rdy"}, 64'(bad_wait), 64'd0);
    chk({tag, ".busy_rdy"}, 64'(bad_rdy), 64'd0);
    chk({tag, ".done1_at"}, 64'(t1), 64'd64);
    chk({tag, ".done2_at"}, 64'(t2), 64'd65);
    chk({tag, ".pt_hi"}, 64'(hi), 64'(exp_pt[63:32]));
    chk({tag, ".pt_lo"}, 64'(lo), 64'(exp_pt[31:0]));
  endtask

  initial begin
    int strobes;
    rst = 1'b1;
    key = '0;
    din = '0;
    din_valid = 1'b0;
    @(negedge clk);
    chk("rst.state", 64'(state), 64'd0);
    chk("rst.dout", 64'(dout), 64'd0);
    chk("rst.done1", 64'(done1), 64'd0);
    chk("rst.done2", 64'(done2), 64'd0);
    chk("rst.ready", 64'(din_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    decrypt("v1", K0, 64'h5579C1387B228445, 0, 1'b0, P0);
    @(negedge clk);
    decrypt("v2_junk", K1, 64'hE72C46C0F5945049, 0, 1'b1, P0);
    @(negedge clk);
    decrypt("v3", K0, 64'hA112FFC72F68417B, 0, 1'b0, P1);
    repeat (3) @(negedge clk);
    chk("hold.dout", 64'(dout), 64'hFFFFFFFF);
    chk("hold.state", 64'(state), 64'd0);
    decrypt("v4_gap", K1, 64'h3333DCD3213210D2, 5, 1'b0, P1);
    @(negedge clk);

    key = K0;
    din = 32'h5579C138;
    din_valid = 1'b1;
    @(negedge clk);
    din = 32'h7B228445;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort.in_round", 64'(state), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("abort.state", 64'(state), 64'd0);
    chk("abort.dout", 64'(dout), 64'd0);
    chk("abort.done1", 64'(done1), 64'd0);
    chk("abort.done2", 64'(done2), 64'd0);
    chk("abort.ready", 64'(din_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    repeat (70) begin
      @(negedge clk);
      if (done1 || done2) strobes++;
    end
    chk("abort.no_strobe", 64'(strobes), 64'd0);
    chk("abort.idle", 64'(state), 64'd0);
    decrypt("post_rst", K0, 64'h5579C1387B228445, 0, 1'b0, P0);
    @(negedge clk);

    decrypt("b2b_a", K0, 64'h5579C1387B228445, 0, 1'b0, P0);
    decrypt("b2b_b", K0, 64'hA112FFC72F68417B, 0, 1'b0, P1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
